uart_rx_fifo: RTL and testbench

//  Serial receive front end of the TEP system: oversamples the async RXD pin, deframes
//  8N1 characters and queues them in a small FIFO for the CPU's serial-input port.

---
 rtl/uart_rx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver: 16x oversampling deframer feeding a small byte FIFO
// that the CPU polls through rxready/rxdata and drains with rd.
module uart_rx_fifo #(
  parameter int DIV16 = 27,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          RXD,
  input  logic          rd,
  input  logic          clr_err,
  output logic [7:0]    rxdata,
  output logic          rxready,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          ferr
);

  localparam int PW = (DIV16 > 1) ? $clog2(DIV16) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITH} state_t;

  logic            rxd_p0;
  logic            rxd_p1;
  logic [PW-1:0]   presc;
  logic            tick;
  state_t          state;
  logic [3:0]      sub;
  logic [2:0]      bitn;
  logic [7:0]      shift;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wrptr;
  logic [AW-1:0]   rdptr;
  logic            stop_smp;
  logic            push;
  logic            ferr_evt;
  logic            full;
  logic            do_rd;
  logic            do_push;
  logic            ovr_evt;

  function automatic logic [AW:0] next_count(input logic [AW:0] c,
                                             input logic inc, input logic dec);
    logic [AW:0] n;
    n = c;
    if (inc && !dec) n = c + 1'b1;
    if (dec && !inc) n = c - 1'b1;
    return n;
  endfunction

  // Stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset || tick) presc <= '0;
    else                 presc <= presc + 1'b1;
  end

  assign tick = (presc == PW'(DIV16 - 1));

  // Deframer: start is re-qualified mid-bit, data and stop sampled 16 ticks apart
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state <= IDLE;
      sub   <= '0;
      bitn  <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rxd_p1) begin
            state <= START;
            sub   <= '0;
          end
        end
        START: begin
          if (sub == 4'd7) begin
            sub   <= '0;
            bitn  <= '0;
            state <= rxd_p1 ? IDLE : DATA;
          end else begin
            sub <= sub + 4'd1;
          end
        end
        DATA: begin
          if (sub == 4'd15) begin
            sub  <= '0;
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            sub <= sub + 4'd1;
          end
        end
        STOP: begin
          if (sub == 4'd15) begin
            sub   <= '0;
            state <= rxd_p1 ? IDLE : WAITH;
          end else begin
            sub <= sub + 4'd1;
          end
        end
        WAITH: begin
          if (rxd_p1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clock) begin
    if (tick && state == DATA && sub == 4'd15) shift[bitn] <= rxd_p1;
  end

  assign stop_smp = tick && (state == STOP) && (sub == 4'd15);
  assign push     = stop_smp && rxd_p1;
  assign ferr_evt = stop_smp && !rxd_p1;

  // A pop frees the slot a simultaneous push needs, so full+rd+push never overruns
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd && (count != '0);
  assign do_push = push && (!full || do_rd);
  assign ovr_evt = push && full && !do_rd;

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      wrptr   <= '0;
      rdptr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (do_push) wrptr <= wrptr + 1'b1;
      if (do_rd)   rdptr <= rdptr + 1'b1;
      count   <= next_count(count, do_push, do_rd);
      overrun <= ovr_evt  | (overrun & ~clr_err);
      ferr    <= ferr_evt | (ferr & ~clr_err);
    end
  end

  always_ff @(posedge m_clock) begin
    if (do_push) mem[wrptr] <= shift;
  end

  assign rxready = (count != '0);
  assign rxdata  = rxready ? mem[rdptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DIV16=1 (one bit = 16 clocks); a
// transaction-level FIFO model is compared against the DUT every cycle.
module tb_uart_rx_fifo;

  localparam int LAT = 155;  // clocks from start-edge drive to the stop-sample edge

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       RXD     = 1'b1;
  logic       rd      = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rxdata;
  logic       rxready;
  logic [3:0] count;
  logic       overrun;
  logic       ferr;

  uart_rx_fifo #(.DIV16(1), .DEPTH(8), .AW(3)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .RXD     (RXD),
    .rd      (rd),
    .clr_err (clr_err),
    .rxdata  (rxdata),
    .rxready (rxready),
    .count   (count),
    .overrun (overrun),
    .ferr    (ferr)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         good;
  } ev_t;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  bit         chk_en = 0;
  ev_t        pend[$];
  logic [7:0] mq[$];
  bit         m_ovr  = 0;
  bit         m_ferr = 0;
  bit         m_push, m_good, m_ovr_set, m_ferr_set, m_do_rd;
  logic [7:0] m_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a finished frame lands in the queue (or raises ferr) exactly LAT clocks after its start edge
  always @(posedge m_clock) begin
    cyc = cyc + 1;
    if (p_reset) begin
      mq.delete();
      pend.delete();
      m_ovr  = 0;
      m_ferr = 0;
    end else begin
      m_push = 0; m_good = 0; m_d = 8'h00; m_ovr_set = 0; m_ferr_set = 0;
      if (pend.size() > 0 && pend[0].at == cyc) begin
        m_push = 1;
        m_good = pend[0].good;
        m_d    = pend[0].data;
        void'(pend.pop_front());
      end
      m_do_rd = rd && (mq.size() > 0);
      if (m_push && m_good && mq.size() == 8 && !m_do_rd) m_ovr_set = 1;
      if (m_do_rd) void'(mq.pop_front());
      if (m_push && m_good && !m_ovr_set) mq.push_back(m_d);
      if (m_push && !m_good) m_ferr_set = 1;
      m_ovr  = m_ovr_set  | (m_ovr  & !clr_err);
      m_ferr = m_ferr_set | (m_ferr & !clr_err);
    end
  end

  always @(negedge m_clock) begin
    if (chk_en) begin
      check("rxready", rxready, (mq.size() != 0));
      check("count", count, mq.size());
      check("overrun", overrun, m_ovr);
      check("ferr", ferr, m_ferr);
      if (mq.size() != 0) check("rxdata", rxdata, mq[0]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge m_clock); #1;
    end
  endtask

  // rd_at/clr_at/rst_at: frame clock index at which that strobe is driven (-1 = never)
  task automatic send_frame(input logic [7:0] b, input bit stop, input int rd_at,
                            input int clr_at, input int rst_at, input bit lat_chk);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 160; i++) begin
      @(posedge m_clock); #1;
      if (i == 0) begin
        e.at = cyc + LAT; e.data = b; e.good = stop;
        pend.push_back(e);
      end
      RXD     = bits[i >> 4];
      rd      = (i == rd_at);
      clr_err = (i == clr_at);
      p_reset = (i == rst_at);
      if (lat_chk && i == LAT - 1) check("latency_before_stop", rxready, 1'b0);
      if (lat_chk && i == LAT)     check("latency_at_stop", rxready, 1'b1);
      if (i == rst_at) begin
        RXD = 1'b1;
        @(posedge m_clock); #1;
        p_reset = 1'b0;
        break;
      end
    end
    rd = 1'b0; clr_err = 1'b0; RXD = 1'b1;
  endtask

  task automatic pop(input logic [7:0] exp);
    @(negedge m_clock);
    check("pop_data", rxdata, exp);
    @(posedge m_clock); #1 rd = 1'b1;
    @(posedge m_clock); #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge m_clock); #1 clr_err = 1'b1;
    @(posedge m_clock); #1 clr_err = 1'b0;
  endtask

  initial begin
    idle(3);
    p_reset = 1'b0;
    chk_en  = 1;
    @(negedge m_clock);
    check("rst_rxready", rxready, 1'b0);
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_count", count, 4'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ferr", ferr, 1'b0);

    // single good frame, then pop it; a pop on empty is ignored
    send_frame(8'h41, 1'b1, -1, -1, -1, 1'b1);
    @(negedge m_clock);
    check("t1_rxready", rxready, 1'b1);
    check("t1_rxdata", rxdata, 8'h41);
    check("t1_count", count, 4'd1);
    pop(8'h41);
    @(negedge m_clock);
    check("t1_empty", count, 4'd0);
    @(posedge m_clock); #1 rd = 1'b1;
    @(posedge m_clock); #1 rd = 1'b0;
    @(negedge m_clock);
    check("rd_empty_count", count, 4'd0);
    check("rd_empty_overrun", overrun, 1'b0);

    // nine frames into eight slots
    for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1, -1, -1, -1, 1'b0);
    @(negedge m_clock);
    check("t2_count", count, 4'd8);
    check("t2_overrun", overrun, 1'b1);
    for (int b = 0; b < 8; b++) pop(8'(b));
    @(negedge m_clock);
    check("t2_drained", count, 4'd0);
    pulse_clr();
    @(negedge m_clock);
    check("t2_clr_overrun", overrun, 1'b0);

    // bad stop bit with clr_err on the same edge: the set wins
    send_frame(8'h55, 1'b0, -1, 154, -1, 1'b0);
    @(negedge m_clock);
    check("t3_ferr", ferr, 1'b1);
    check("t3_count", count, 4'd0);
    idle(32);
    send_frame(8'hAA, 1'b1, -1, -1, -1, 1'b0);
    @(negedge m_clock);
    check("t3_rxdata", rxdata, 8'hAA);
    pulse_clr();
    @(negedge m_clock);
    check("t3_clr_ferr", ferr, 1'b0);
    pop(8'hAA);

    // 4-clock glitch on the line
    @(posedge m_clock); #1 RXD = 1'b0;
    idle(4);
    RXD = 1'b1;
    idle(40);
    @(negedge m_clock);
    check("t4_count", count, 4'd0);
    check("t4_ferr", ferr, 1'b0);
    check("t4_overrun", overrun, 1'b0);

    // reset in the middle of data bit 4 clears a non-empty FIFO
    send_frame(8'h77, 1'b1, -1, -1, -1, 1'b0);
    send_frame(8'hC3, 1'b1, -1, -1, 85, 1'b0);
    @(negedge m_clock);
    check("t5_rst_count", count, 4'd0);
    check("t5_rst_rxready", rxready, 1'b0);
    check("t5_rst_rxdata", rxdata, 8'h00);
    idle(40);
    send_frame(8'h3C, 1'b1, -1, -1, -1, 1'b0);
    @(negedge m_clock);
    check("t5_count", count, 4'd1);
    check("t5_rxdata", rxdata, 8'h3C);
    pop(8'h3C);

    // full FIFO, rd lands on the stop-sample edge of 0x99
    for (int b = 16; b < 24; b++) send_frame(8'(b), 1'b1, -1, -1, -1, 1'b0);
    send_frame(8'h99, 1'b1, 154, -1, -1, 1'b0);
    @(negedge m_clock);
    check("t6_count", count, 4'd8);
    check("t6_overrun", overrun, 1'b0);
    for (int b = 17; b < 24; b++) pop(8'(b));
    pop(8'h99);
    @(negedge m_clock);
    check("t6_drained", count, 4'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
